// File: rtl/instr_pkg.sv
// Shared opcode constants, op enum and word field positions for the program writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_pkg;

  // Operation selector carried on in_op; codes 10..15 are illegal.
  typedef enum logic [3:0] {
    OP_COPY  = 4'd0,
    OP_FILL  = 4'd1,
    OP_EMPTY = 4'd2,
    OP_LDI   = 4'd3,
    OP_ADD   = 4'd4,
    OP_SUB   = 4'd5,
    OP_DIV   = 4'd6,
    OP_MUL   = 4'd7,
    OP_SHL   = 4'd8,
    OP_SHR   = 4'd9
  } op_e;

  localparam logic [16:0] OPC_COPY  = 17'b10000000010101010;
  localparam logic [16:0] OPC_FILL  = 17'b10000001101010101;
  localparam logic [16:0] OPC_EMPTY = 17'b10000010011011011;
  localparam logic [16:0] OPC_LDI   = 17'b10000011111111111;
  localparam logic [16:0] OPC_ADD   = 17'b10000101101111100;
  localparam logic [16:0] OPC_SUB   = 17'b10001011010101010;
  localparam logic [16:0] OPC_DIV   = 17'b10000111000000001;
  localparam logic [16:0] OPC_MUL   = 17'b10001000101111011;
  localparam logic [16:0] OPC_SHL   = 17'b10001001011110110;
  localparam logic [16:0] OPC_SHR   = 17'b10001010101110111;

  // Field positions inside a 32-bit program word.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 15;
  localparam int A_MSB   = 14;
  localparam int A_LSB   = 10;
  localparam int B_MSB   = 9;
  localparam int B_LSB   = 5;

  // Pack opcode and operands into a word; the low 5 bits are always zero.
  function automatic logic [31:0] pack_word(input logic [16:0] opc,
                                            input logic [4:0]  a,
                                            input logic [4:0]  b);
    logic [31:0] w;
    w                  = '0;
    w[OPC_MSB:OPC_LSB] = opc;
    w[A_MSB:A_LSB]     = a;
    w[B_MSB:B_LSB]     = b;
    return w;
  endfunction

  // Recover the 17-bit opcode field from a stored word.
  function automatic logic [16:0] word_opcode(input logic [31:0] w);
    return w[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational encoder: op/a/b tuple to 32-bit program word plus illegal-op flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs every cycle.
module instr_encode
  import instr_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [4:0]  i_a,
  input  logic [4:0]  i_b,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  logic [16:0] w_opc;

  // Map the op code onto its 17-bit opcode; anything outside 0..9 is flagged.
  always_comb begin
    w_opc     = '0;
    o_illegal = 1'b0;
    case (i_op)
      OP_COPY:  w_opc = OPC_COPY;
      OP_FILL:  w_opc = OPC_FILL;
      OP_EMPTY: w_opc = OPC_EMPTY;
      OP_LDI:   w_opc = OPC_LDI;
      OP_ADD:   w_opc = OPC_ADD;
      OP_SUB:   w_opc = OPC_SUB;
      OP_DIV:   w_opc = OPC_DIV;
      OP_MUL:   w_opc = OPC_MUL;
      OP_SHL:   w_opc = OPC_SHL;
      OP_SHR:   w_opc = OPC_SHR;
      default:  o_illegal = 1'b1;
    endcase
  end

  assign o_word = pack_word(w_opc, i_a, i_b);

endmodule

// File: rtl/instr_program_writer.sv
// Loads a stream of instruction tuples into a 32-entry program memory with a registered read port.
// Latency: tuple written on the accepting edge; rd_data valid one cycle after rd_addr.
// Backpressure: in_ready low outside LOAD and once the memory is full.
module instr_program_writer
  import instr_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_a,
  input  logic [4:0]  in_b,
  input  logic        in_last,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [5:0]  prog_len,
  output logic        done,
  output logic        err_illegal
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [5:0] FULL_CNT = 6'(DEPTH);
  localparam logic [5:0] LAST_IDX = 6'(DEPTH - 1);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [5:0]  r_wr_ptr;
  logic        r_err;
  logic [31:0] r_rd_data;
  logic [31:0] r_mem [0:DEPTH-1];

  logic [31:0] w_word;
  logic        w_illegal;
  logic        w_in_ready;
  logic        w_clear;
  logic        w_wr;
  logic        w_set_err;

  instr_encode u_encode (
    .i_op      (in_op),
    .i_a       (in_a),
    .i_b       (in_b),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and per-cycle control; start always wins over a presented tuple.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_clear     = 1'b0;
    w_wr        = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_in_ready = (r_wr_ptr < FULL_CNT);
        if (start) begin
          w_clear = 1'b1;
        end else if (in_valid && w_in_ready) begin
          if (w_illegal) w_set_err = 1'b1;
          else           w_wr      = 1'b1;
          // The write into the last free slot ends the load on its own.
          if (in_last || (!w_illegal && r_wr_ptr == LAST_IDX))
            w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Write pointer (doubles as program length), sticky error and registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[rd_addr];
      if (w_clear) begin
        r_wr_ptr <= '0;
        r_err    <= 1'b0;
      end else begin
        if (w_wr)      r_wr_ptr <= r_wr_ptr + 6'd1;
        if (w_set_err) r_err    <= 1'b1;
      end
    end
  end

  // Program memory is never reset so a reader can still see the last program.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[4:0]] <= w_word;
  end

  assign in_ready    = w_in_ready;
  assign rd_data     = r_rd_data;
  assign prog_len    = r_wr_ptr;
  assign done        = (r_state == ST_DONE);
  assign err_illegal = r_err;

endmodule

// File: tb/tb_instr_program_writer.sv
module tb_instr_program_writer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_a;
  logic [4:0]  in_b;
  logic        in_last;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [5:0]  prog_len;
  logic        done;
  logic        err_illegal;

  int n_vec;
  int n_miss;

  // Hand-written opcode constants, independent of the design package.
  localparam logic [16:0] C_COPY  = 17'b10000000010101010;
  localparam logic [16:0] C_FILL  = 17'b10000001101010101;
  localparam logic [16:0] C_EMPTY = 17'b10000010011011011;
  localparam logic [16:0] C_ADD   = 17'b10000101101111100;
  localparam logic [16:0] C_SUB   = 17'b10001011010101010;
  localparam logic [16:0] C_DIV   = 17'b10000111000000001;
  localparam logic [16:0] C_SHL   = 17'b10001001011110110;

  instr_program_writer #(.DEPTH(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_last     (in_last),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .prog_len    (prog_len),
    .done        (done),
    .err_illegal (err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wrd(input logic [16:0] opc, input logic [4:0] a, input logic [4:0] b);
    return {opc, a, b, 5'b00000};
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic rd(input logic [4:0] addr, output logic [31:0] data);
    @(negedge clk);
    rd_addr = addr;
    @(posedge clk);
    #1 data = rd_data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    n_vec    = 0;
    n_miss   = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_op    = 4'd0;
    in_a     = 5'd0;
    in_b     = 5'd0;
    in_last  = 1'b0;
    rd_addr  = 5'd0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",  32'(in_ready),    32'd0);
    chk("rst_done",   32'(done),        32'd0);
    chk("rst_err",    32'(err_illegal), 32'd0);
    chk("rst_len",    32'(prog_len),    32'd0);
    chk("rst_rdata",  rd_data,          32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single add with last.
    pulse_start();
    chk("load_ready", 32'(in_ready), 32'd1);
    send(4'd4, 5'd3, 5'd5, 1'b1);
    chk("add_done",   32'(done),     32'd1);
    chk("add_len",    32'(prog_len), 32'd1);
    chk("add_ready",  32'(in_ready), 32'd0);
    rd(5'd0, d);
    chk("add_mem0",   d, 32'b10000101101111100_00011_00101_00000);

    // Illegal op, then a legal copy.
    pulse_start();
    chk("ill_clr_len",  32'(prog_len), 32'd0);
    chk("ill_clr_done", 32'(done),     32'd0);
    send(4'd12, 5'd7, 5'd7, 1'b0);
    chk("ill_err",    32'(err_illegal), 32'd1);
    chk("ill_len",    32'(prog_len),    32'd0);
    chk("ill_nodone", 32'(done),        32'd0);
    send(4'd0, 5'd1, 5'd2, 1'b1);
    chk("copy_err",   32'(err_illegal), 32'd1);
    chk("copy_len",   32'(prog_len),    32'd1);
    chk("copy_done",  32'(done),        32'd1);
    rd(5'd0, d);
    chk("copy_mem0",  d, wrd(C_COPY, 5'd1, 5'd2));

    // Illegal op carrying last still ends the load.
    pulse_start();
    chk("start_err_clr", 32'(err_illegal), 32'd0);
    send(4'd15, 5'd0, 5'd0, 1'b1);
    chk("ill_last_done", 32'(done),        32'd1);
    chk("ill_last_len",  32'(prog_len),    32'd0);
    chk("ill_last_err",  32'(err_illegal), 32'd1);

    // Restart mid-load; the tuple presented with start is dropped.
    pulse_start();
    for (int i = 0; i < 3; i++) send(4'd5, 5'(i), 5'(i), 1'b0);
    send(4'd11, 5'd0, 5'd0, 1'b0);
    chk("mid_len3", 32'(prog_len),    32'd3);
    chk("mid_err",  32'(err_illegal), 32'd1);
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    in_op    = 4'd7;
    in_a     = 5'd9;
    in_b     = 5'd9;
    in_last  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("restart_len",  32'(prog_len),    32'd0);
    chk("restart_err",  32'(err_illegal), 32'd0);
    chk("restart_load", 32'(done),        32'd0);
    send(4'd6, 5'd4, 5'd4, 1'b1);
    chk("restart_len1", 32'(prog_len),    32'd1);
    chk("restart_err0", 32'(err_illegal), 32'd0);
    chk("restart_done", 32'(done),        32'd1);
    rd(5'd0, d);
    chk("restart_mem0", d, wrd(C_DIV, 5'd4, 5'd4));
    rd(5'd1, d);
    chk("stale_mem1",   d, wrd(C_SUB, 5'd1, 5'd1));

    // Fill all 32 entries without last.
    pulse_start();
    for (int i = 0; i < 32; i++) begin
      send(4'd8, 5'(i), 5'(31 - i), 1'b0);
      if (i == 30) begin
        chk("full_ready31", 32'(in_ready), 32'd1);
        chk("full_nodone",  32'(done),     32'd0);
      end
    end
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_done",  32'(done),     32'd1);
    chk("full_len",   32'(prog_len), 32'd32);
    send(4'd8, 5'd1, 5'd1, 1'b0);
    chk("full_hold",  32'(prog_len), 32'd32);
    rd(5'd0, d);
    chk("full_mem0",  d, wrd(C_SHL, 5'd0, 5'd31));
    rd(5'd31, d);
    chk("full_mem31", d, wrd(C_SHL, 5'd31, 5'd0));

    // Read and write entry 0 in the same cycle.
    pulse_start();
    @(negedge clk);
    rd_addr  = 5'd0;
    in_valid = 1'b1;
    in_op    = 4'd1;
    in_a     = 5'd9;
    in_b     = 5'd10;
    in_last  = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("rw_old", rd_data, wrd(C_SHL, 5'd0, 5'd31));
    @(posedge clk);
    #1;
    chk("rw_new", rd_data, wrd(C_FILL, 5'd9, 5'd10));

    // Reset after four writes; memory survives.
    for (int i = 1; i < 4; i++) send(4'd2, 5'(i), 5'(i + 1), 1'b0);
    chk("pre_rst_len", 32'(prog_len), 32'd4);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_len",   32'(prog_len), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_rdata", rd_data,       32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(5'd2, d);
    chk("rst_keep_mem2", d, wrd(C_EMPTY, 5'd2, 5'd3));
    send(4'd4, 5'd1, 5'd1, 1'b1);
    chk("idle_ignore_len",  32'(prog_len), 32'd0);
    chk("idle_ignore_done", 32'(done),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
